// File: rtl/irq_timer_ctrl_if.sv
// irq_timer_ctrl_if: data-bus slave port bundle for the interrupt/timer block.
//   iAddress     - byte address from the processor
//   iWriteData   - lane-aligned write data
//   iWriteEnable - write strobe
//   iReadEnable  - read strobe
//   iByteEnable  - per-byte write lane enables (bit n covers [8n+7:8n])
//   oReadData    - registered read data, zero when the block is not being read
interface irq_timer_ctrl_if;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] oReadData;

  modport master (
    output iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    input  oReadData
  );

  modport slave (
    input  iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    output oReadData
  );
endinterface

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: memory-mapped interrupt controller with a 32-bit compare timer.
// Seven asynchronous request lines are synchronised and edge- or level-detected
// into PENDING[6:0]; the timer drives PENDING[7]. Pending bits stay set until
// software writes 1 to clear them. The output vector is PENDING & ENABLE.
// Ports:
//   iCLK, iRST         - clock and synchronous active-high reset
//   bus (slave)        - data-bus register access (see irq_timer_ctrl_if)
//   iIrqSrc[6:0]       - asynchronous external requests, active-high
//   oPendingInterrupt  - masked pending vector for the COP0 register bank
// Register offsets (iAddress[4:2]): 0 PENDING (W1C), 1 ENABLE, 2 EDGE_MODE,
// 3 TIMER_CMP, 4 TIMER_CNT, 5 TIMER_CTRL {AUTORELOAD, RUN}, 6/7 reserved.
module irq_timer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  irq_timer_ctrl_if.slave        bus,
  input  logic [6:0]             iIrqSrc,
  output logic [7:0]             oPendingInterrupt
);

  localparam logic [2:0] OFF_PEND = 3'd0;
  localparam logic [2:0] OFF_EN   = 3'd1;
  localparam logic [2:0] OFF_EDGE = 3'd2;
  localparam logic [2:0] OFF_CMP  = 3'd3;
  localparam logic [2:0] OFF_CNT  = 3'd4;
  localparam logic [2:0] OFF_CTRL = 3'd5;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic [6:0]  sync1_q, sync1_d;
  logic [6:0]  sync2_q, sync2_d;
  logic [6:0]  prev_q,  prev_d;
  logic [7:0]  pend_q,  pend_d;
  logic [7:0]  en_q,    en_d;
  logic [6:0]  edge_q,  edge_d;
  logic [31:0] cmp_q,   cmp_d;
  logic [31:0] cnt_q,   cnt_d;
  logic        run_q,   run_d;
  logic        auto_q,  auto_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sel;
  logic        wr;
  logic        rd;
  logic [2:0]  off;
  logic        match;
  logic [6:0]  ext_set;
  logic [7:0]  clr;
  logic        unused_addr_lsb;

  assign sel             = (bus.iAddress[31:5] == BASE_ADDR[31:5]);
  assign wr              = bus.iWriteEnable & sel;
  assign rd              = bus.iReadEnable & sel;
  assign off             = bus.iAddress[4:2];
  assign unused_addr_lsb = ^bus.iAddress[1:0];

  always_comb begin
    sync1_d = iIrqSrc;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    en_d    = en_q;
    edge_d  = edge_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    auto_d  = auto_q;
    rdata_d = 32'd0;

    // Timer compares the pre-update count; a match reloads to zero and
    // stops the timer unless autoreload is on.
    match = run_q && (cnt_q == cmp_q);
    if (run_q) begin
      if (match) begin
        cnt_d = 32'd0;
        if (!auto_q) run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    // Edge sources set on a synchronised rising edge; level sources set every
    // cycle the line is high, so a clear only sticks once the line drops.
    ext_set = (sync2_q & ~prev_q & edge_q) | (sync2_q & ~edge_q);

    clr = 8'd0;
    if (wr && off == OFF_PEND && bus.iByteEnable[0]) clr = bus.iWriteData[7:0];

    // Set has priority over a same-cycle clear.
    pend_d = {match, ext_set} | (pend_q & ~clr);

    // Bus writes land after the timer update so they override it.
    if (wr) begin
      case (off)
        OFF_EN:   if (bus.iByteEnable[0]) en_d = bus.iWriteData[7:0];
        OFF_EDGE: if (bus.iByteEnable[0]) edge_d = bus.iWriteData[6:0];
        OFF_CMP:  cmp_d = merge_bytes(cmp_q, bus.iWriteData, bus.iByteEnable);
        OFF_CNT:  cnt_d = merge_bytes(cnt_d, bus.iWriteData, bus.iByteEnable);
        OFF_CTRL: if (bus.iByteEnable[0]) begin
                    run_d  = bus.iWriteData[0];
                    auto_d = bus.iWriteData[1];
                  end
        default:  ;
      endcase
    end

    // Reads see pre-write register contents.
    if (rd) begin
      case (off)
        OFF_PEND: rdata_d = {24'd0, pend_q};
        OFF_EN:   rdata_d = {24'd0, en_q};
        OFF_EDGE: rdata_d = {24'd0, 1'b1, edge_q};
        OFF_CMP:  rdata_d = cmp_q;
        OFF_CNT:  rdata_d = cnt_q;
        OFF_CTRL: rdata_d = {30'd0, auto_q, run_q};
        default:  rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      auto_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      edge_q  <= edge_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      auto_q  <= auto_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.oReadData     = rdata_q;
  assign oPendingInterrupt = pend_q & en_q;

endmodule
